// File: rtl/cprv_pkg.sv
// cprv_pkg: shared types and defaults for the cprv fetch path.
//   XLEN             - PC / datapath width
//   ILEN             - instruction width
//   RESET_PC_DEFAULT - fetch PC after reset
//   fetch_entry_t    - one buffered instruction together with its PC
package cprv_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/cprv_sync_fifo.sv
// cprv_sync_fifo: single-clock FIFO with a synchronous flush.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset (clears storage too)
//   flush          - empties the FIFO next cycle; push/pop ignored that cycle
//   push/push_data - write one entry (accepted when not full, or when popping)
//   pop            - remove the head entry (ignored when empty)
//   head           - current head entry, read straight from the storage flops
//   count/empty/full - occupancy
module cprv_sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  T            mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit so count is a plain subtraction.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/cprv_fetch_unit.sv
// cprv_fetch_unit: sequential instruction fetch with redirect support.
// Ports:
//   clk, rst_n                         - clock, synchronous active-low reset
//   valid_imem/ready_imem              - fetch request handshake
//   instr_addr_imem                    - fetch byte address (low bits of pc)
//   valid_if/ready_if/instr_data_imem  - imem response (ready_if is always 1)
//   redirect_valid/redirect_pc         - branch/jump redirect
//   valid_id/ready_id/instr_id/pc_id   - instruction delivery to decode
//   perf_bubble_cnt                    - only when CPRV_FETCH_PERF_EN is defined:
//                                        cycles where decode was ready but
//                                        no instruction was offered
// Mode is implied by drop_cnt: non-zero means stale responses are still
// being discarded after a redirect; requests keep flowing meanwhile.
module cprv_fetch_unit
  import cprv_pkg::*;
#(
  parameter int                   XLEN        = cprv_pkg::XLEN,
  parameter int                   IADDR_WIDTH = 32,
  parameter int                   FIFO_DEPTH  = 4,
  parameter logic [XLEN-1:0]      RESET_PC    = cprv_pkg::RESET_PC_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    valid_imem,
  input  logic                    ready_imem,
  output logic [IADDR_WIDTH-1:0]  instr_addr_imem,
  input  logic                    valid_if,
  output logic                    ready_if,
  input  logic [31:0]             instr_data_imem,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  output logic                    valid_id,
  input  logic                    ready_id,
  output logic [31:0]             instr_id,
  output logic [XLEN-1:0]         pc_id
`ifdef CPRV_FETCH_PERF_EN
  ,
  output logic [31:0]             perf_bubble_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     in_use;
  logic            fifo_empty;
  logic            fifo_full;
  logic            req_fire;
  logic            push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Every in-flight request already owns a FIFO slot, so responses can
  // never be refused.
  assign in_use          = {1'b0, outstanding} + {1'b0, fifo_count};
  assign valid_imem      = rst_n && !redirect_valid && (in_use < (CW+1)'(FIFO_DEPTH));
  assign instr_addr_imem = pc[IADDR_WIDTH-1:0];
  assign ready_if        = 1'b1;
  assign req_fire        = valid_imem && ready_imem;

  // A response in a redirect cycle belongs to the old stream: drop it.
  assign push       = valid_if && !redirect_valid && (drop_cnt == '0) && (!fifo_full || pop);
  assign valid_id   = !fifo_empty && !redirect_valid;
  assign pop        = valid_id && ready_id;
  assign push_entry = '{pc: resp_pc, instr: instr_data_imem};
  assign instr_id   = head.instr;
  assign pc_id      = head.pc;

  cprv_sync_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      // No request fires this cycle, so only the response can change the
      // in-flight count; whatever remains in flight is stale.
      pc          <= redirect_pc;
      resp_pc     <= redirect_pc;
      outstanding <= outstanding - CW'(valid_if);
      drop_cnt    <= outstanding - CW'(valid_if);
    end else begin
      if (req_fire) pc <= pc + XLEN'(4);
      if (push) resp_pc <= resp_pc + XLEN'(4);
      outstanding <= outstanding + CW'(req_fire) - CW'(valid_if);
      if (valid_if && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
    end
  end

`ifdef CPRV_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) perf_bubble_cnt <= '0;
    else if (ready_id && !valid_id) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_cprv_fetch_unit.sv
module tb_cprv_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_imem;
  logic        ready_imem = 1'b0;
  logic [31:0] instr_addr_imem;
  logic        valid_if = 1'b0;
  logic        ready_if;
  logic [31:0] instr_data_imem = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        valid_id;
  logic        ready_id = 1'b0;
  logic [31:0] instr_id;
  logic [63:0] pc_id;
`ifdef CPRV_FETCH_PERF_EN
  logic [31:0] perf_bubble_cnt;
`endif

  always #5 clk = ~clk;

  cprv_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_imem      (valid_imem),
    .ready_imem      (ready_imem),
    .instr_addr_imem (instr_addr_imem),
    .valid_if        (valid_if),
    .ready_if        (ready_if),
    .instr_data_imem (instr_data_imem),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .valid_id        (valid_id),
    .ready_id        (ready_id),
    .instr_id        (instr_id),
    .pc_id           (pc_id)
`ifdef CPRV_FETCH_PERF_EN
    ,
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } resp_t;

  resp_t       resp_q[$];
  logic [31:0] req_addr[$];
  int          req_tag[$];
  int          req_cyc[$];
  logic [63:0] got_pc[$];
  logic [31:0] got_ins[$];
  int          got_tag[$];
  int          got_cyc[$];
  logic [63:0] targets[$];
  int          tag, cyc, lat, tests, fails;
  logic        rst_drv;
  logic        last_vimem, last_vid;

  // Instruction memory contents: a distinctive word per address.
  function automatic logic [31:0] imem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic clear_logs();
    req_addr.delete(); req_tag.delete(); req_cyc.delete();
    got_pc.delete(); got_ins.delete(); got_tag.delete(); got_cyc.delete();
    targets.delete();
    targets.push_back(64'h0);
    tag = 0;
  endtask

  // One clock: drive inputs at negedge, observe settled outputs, log fires.
  task automatic cycle(input logic rdir, input logic [63:0] rpc,
                       input logic rid, input logic rimem);
    resp_t r;
    @(negedge clk);
    rst_n          = rst_drv;
    redirect_valid = rdir;
    redirect_pc    = rpc;
    ready_id       = rid;
    ready_imem     = rimem;
    valid_if       = 1'b0;
    instr_data_imem = '0;
    if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      r = resp_q.pop_front();
      valid_if        = 1'b1;
      instr_data_imem = imem_data(r.addr);
    end
    #1;
    if (valid_imem && ready_imem) begin
      resp_q.push_back('{addr: instr_addr_imem, due: cyc + lat});
      req_addr.push_back(instr_addr_imem);
      req_tag.push_back(tag);
      req_cyc.push_back(cyc);
    end
    if (valid_id && ready_id) begin
      got_pc.push_back(pc_id);
      got_ins.push_back(instr_id);
      got_tag.push_back(tag);
      got_cyc.push_back(cyc);
    end
    last_vimem = valid_imem;
    last_vid   = valid_id;
    if (rdir) begin
      tag++;
      targets.push_back(rpc);
    end
    cyc++;
  endtask

  task automatic do_reset();
    resp_q.delete();
    rst_drv = 1'b0;
    repeat (2) cycle(1'b0, 64'h0, 1'b0, 1'b0);
    clear_logs();
    rst_drv = 1'b1;
  endtask

  task automatic test_reset();
    lat = 2;
    rst_drv = 1'b1;
    repeat (6) cycle(1'b0, 64'h0, 1'b1, 1'b1);
    do_reset();
    tests++; if (last_vimem !== 1'b0) begin fails++; $display("FAIL reset_valid_imem: got %b expected 0", last_vimem); end
    tests++; if (valid_id !== 1'b0) begin fails++; $display("FAIL reset_valid_id: got %b expected 0", valid_id); end
    tests++; if (instr_id !== 32'h0) begin fails++; $display("FAIL reset_instr_id: got %h expected 0", instr_id); end
    tests++; if (pc_id !== 64'h0) begin fails++; $display("FAIL reset_pc_id: got %h expected 0", pc_id); end
    cycle(1'b0, 64'h0, 1'b1, 1'b1);
    tests++;
    if (req_addr.size() != 1 || req_addr[0] !== 32'h0) begin
      fails++; $display("FAIL reset_first_req: %0d requests, first expected addr 0", req_addr.size());
    end
  endtask

  task automatic test_sequential();
    do_reset();
    lat = 1;
    repeat (14) cycle(1'b0, 64'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (req_addr.size() <= i || req_addr[i] !== 32'(4*i)) begin
        fails++; $display("FAIL seq_req_addr[%0d]: got %h expected %h", i, (req_addr.size() > i) ? req_addr[i] : 32'hx, 32'(4*i));
      end
    end
    tests++;
    if (got_pc.size() < 8) begin
      fails++; $display("FAIL seq_delivered: got %0d expected >= 8", got_pc.size());
    end else begin
      tests++;
      if (got_cyc[0] - req_cyc[0] != 2) begin
        fails++; $display("FAIL seq_latency: got %0d expected 2", got_cyc[0] - req_cyc[0]);
      end
      for (int i = 0; i < 8; i++) begin
        tests++; if (got_pc[i] !== 64'(4*i)) begin fails++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, got_pc[i], 64'(4*i)); end
        tests++; if (got_ins[i] !== imem_data(32'(4*i))) begin fails++; $display("FAIL seq_instr[%0d]: got %h expected %h", i, got_ins[i], imem_data(32'(4*i))); end
        tests++; if (got_cyc[i] != got_cyc[0] + i) begin fails++; $display("FAIL seq_cycle[%0d]: got %0d expected %0d", i, got_cyc[i], got_cyc[0] + i); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    lat = 1;
    repeat (10) cycle(1'b0, 64'h0, 1'b0, 1'b1);
    tests++; if (req_addr.size() != 4) begin fails++; $display("FAIL bp_req_count: got %0d expected 4", req_addr.size()); end
    tests++; if (last_vimem !== 1'b0) begin fails++; $display("FAIL bp_valid_imem: got %b expected 0", last_vimem); end
    tests++; if (last_vid !== 1'b1) begin fails++; $display("FAIL bp_valid_id: got %b expected 1", last_vid); end
    tests++; if (pc_id !== 64'h0) begin fails++; $display("FAIL bp_head_pc: got %h expected 0", pc_id); end
    repeat (12) cycle(1'b0, 64'h0, 1'b1, 1'b1);
    tests++;
    if (got_pc.size() < 6) begin
      fails++; $display("FAIL bp_delivered: got %0d expected >= 6", got_pc.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests++; if (got_pc[i] !== 64'(4*i)) begin fails++; $display("FAIL bp_pc[%0d]: got %h expected %h", i, got_pc[i], 64'(4*i)); end
        tests++; if (got_ins[i] !== imem_data(32'(4*i))) begin fails++; $display("FAIL bp_instr[%0d]: got %h expected %h", i, got_ins[i], imem_data(32'(4*i))); end
      end
    end
    tests++;
    if (req_addr.size() < 5 || req_addr[4] !== 32'h10) begin
      fails++; $display("FAIL bp_resume_addr: %0d requests, fifth expected at 10", req_addr.size());
    end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    lat = 3;
    repeat (2) cycle(1'b0, 64'h0, 1'b1, 1'b1);
    tests++; if (req_addr.size() != 2) begin fails++; $display("FAIL rd_outstanding: got %0d expected 2", req_addr.size()); end
    cycle(1'b1, 64'h100, 1'b1, 1'b1);
    repeat (16) cycle(1'b0, 64'h0, 1'b1, 1'b1);
    tests++;
    if (got_pc.size() < 4) begin
      fails++; $display("FAIL rd_delivered: got %0d expected >= 4", got_pc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++; if (got_pc[i] !== 64'h100 + 64'(4*i)) begin fails++; $display("FAIL rd_pc[%0d]: got %h expected %h", i, got_pc[i], 64'h100 + 64'(4*i)); end
        tests++; if (got_ins[i] !== imem_data(32'h100 + 32'(4*i))) begin fails++; $display("FAIL rd_instr[%0d]: got %h expected %h", i, got_ins[i], imem_data(32'h100 + 32'(4*i))); end
      end
    end
    tests++;
    if (req_addr.size() < 3 || req_addr[2] !== 32'h100) begin
      fails++; $display("FAIL rd_new_req: %0d requests, third expected at 100", req_addr.size());
    end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    lat = 2;
    cycle(1'b0, 64'h0, 1'b1, 1'b1);
    cycle(1'b0, 64'h0, 1'b1, 1'b0);
    // The only outstanding response arrives together with the redirect.
    cycle(1'b1, 64'h180, 1'b1, 1'b0);
    repeat (10) cycle(1'b0, 64'h0, 1'b1, 1'b1);
    tests++;
    if (got_pc.size() < 3 || req_cyc.size() < 2) begin
      fails++; $display("FAIL rs_delivered: got %0d expected >= 3", got_pc.size());
    end else begin
      tests++; if (got_pc[0] !== 64'h180) begin fails++; $display("FAIL rs_pc: got %h expected 180", got_pc[0]); end
      tests++; if (got_ins[0] !== imem_data(32'h180)) begin fails++; $display("FAIL rs_instr: got %h expected %h", got_ins[0], imem_data(32'h180)); end
      tests++; if (got_pc[2] !== 64'h188) begin fails++; $display("FAIL rs_pc2: got %h expected 188", got_pc[2]); end
      tests++; if (got_cyc[0] - req_cyc[1] != lat + 1) begin fails++; $display("FAIL rs_latency: got %0d expected %0d", got_cyc[0] - req_cyc[1], lat + 1); end
    end
  endtask

  task automatic test_back_to_back();
    int nreq;
    do_reset();
    lat = 2;
    repeat (6) cycle(1'b0, 64'h0, 1'b1, 1'b1);
    got_pc.delete(); got_ins.delete();
    nreq = req_addr.size();
    cycle(1'b1, 64'h200, 1'b1, 1'b1);
    cycle(1'b1, 64'h300, 1'b1, 1'b1);
    repeat (16) cycle(1'b0, 64'h0, 1'b1, 1'b1);
    tests++;
    if (got_pc.size() < 6) begin
      fails++; $display("FAIL b2b_delivered: got %0d expected >= 6", got_pc.size());
    end
    for (int i = 0; i < got_pc.size(); i++) begin
      tests++; if (got_pc[i] !== 64'h300 + 64'(4*i)) begin fails++; $display("FAIL b2b_pc[%0d]: got %h expected %h", i, got_pc[i], 64'h300 + 64'(4*i)); end
      tests++; if (got_ins[i] !== imem_data(32'h300 + 32'(4*i))) begin fails++; $display("FAIL b2b_instr[%0d]: got %h expected %h", i, got_ins[i], imem_data(32'h300 + 32'(4*i))); end
    end
    tests++;
    if (req_addr.size() <= nreq || req_addr[nreq] !== 32'h300) begin
      fails++; $display("FAIL b2b_new_req: expected first post-redirect request at 300");
    end
  endtask

  // Reference rule: decode sees, after each redirect (or reset), the
  // instructions at target, target+4, ... in order; requests follow the
  // same address chain.
  task automatic test_random();
    logic [63:0] rpc, exp;
    logic        rdir;
    int          prev, last_cnt;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      lat  = $urandom_range(1, 4);
      rdir = ($urandom_range(0, 99) < 3);
      rpc  = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 9) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0;
      cycle(rdir, rpc, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
    end
    lat = 1;
    repeat (30) cycle(1'b0, 64'h0, 1'b1, 1'b1);
    prev = -1; exp = '0; last_cnt = 0;
    for (int i = 0; i < got_pc.size(); i++) begin
      if (got_tag[i] != prev) begin prev = got_tag[i]; exp = targets[got_tag[i]]; end
      tests++; if (got_pc[i] !== exp) begin fails++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, got_pc[i], exp); end
      tests++; if (got_ins[i] !== imem_data(exp[31:0])) begin fails++; $display("FAIL rnd_instr[%0d]: got %h expected %h", i, got_ins[i], imem_data(exp[31:0])); end
      if (got_tag[i] == tag) last_cnt++;
      exp = exp + 64'd4;
    end
    prev = -1;
    for (int i = 0; i < req_addr.size(); i++) begin
      if (req_tag[i] != prev) begin prev = req_tag[i]; exp = targets[req_tag[i]]; end
      tests++; if (req_addr[i] !== exp[31:0]) begin fails++; $display("FAIL rnd_req[%0d]: got %h expected %h", i, req_addr[i], exp[31:0]); end
      exp = exp + 64'd4;
    end
    tests++; if (last_cnt < 10) begin fails++; $display("FAIL rnd_progress: got %0d expected >= 10", last_cnt); end
  endtask

`ifdef CPRV_FETCH_PERF_EN
  task automatic test_perf();
    do_reset();
    lat = 1;
    tests++; if (perf_bubble_cnt !== 32'd0) begin fails++; $display("FAIL perf_reset: got %0d expected 0", perf_bubble_cnt); end
    repeat (5) cycle(1'b0, 64'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    tests++; if (perf_bubble_cnt !== 32'd5) begin fails++; $display("FAIL perf_bubbles: got %0d expected 5", perf_bubble_cnt); end
  endtask
`endif

  initial begin
    tests = 0; fails = 0; cyc = 0; lat = 1; rst_drv = 1'b0;
    clear_logs();
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drop();
    test_redirect_same_cycle();
    test_back_to_back();
    test_random();
`ifdef CPRV_FETCH_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
